// File: rtl/voxel_rmw_scheduler.sv
// voxel_rmw_scheduler: voxel BRAM read-modify-write scheduler with forwarding, two-deep coalescing and clear sweep
module voxel_rmw_scheduler #(
  parameter int ADDR_W  = 15,
  parameter int COORD_W = 10,
  parameter int COUNT_W = 8,
  parameter int SUM_W   = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [ADDR_W-1:0]          upd_addr,
  input  logic [COORD_W-1:0]         upd_x,
  input  logic [COORD_W-1:0]         upd_y,
  input  logic [COORD_W-1:0]         upd_z,
  input  logic                       frame_clear,
  output logic                       busy,
  output logic                       clear_done,
  output logic [ADDR_W-1:0]          bram_addr,
  output logic                       bram_re,
  input  logic [COUNT_W+3*SUM_W-1:0] bram_rdata,
  output logic                       bram_we,
  output logic [COUNT_W+3*SUM_W-1:0] bram_wdata
);
  localparam int W = COUNT_W + 3*SUM_W;
  typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;
  function automatic logic [SUM_W-1:0] sat(input logic [SUM_W-1:0] a, input logic [COORD_W-1:0] x);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W+1-COORD_W){1'b0}}, x};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d, s1_addr_q, wr_addr_q;
  logic [COORD_W-1:0] s1_x_q, s1_y_q, s1_z_q;
  logic [W-1:0] s1_acc_q, wr_data_q, base, merged;
  logic [COUNT_W-1:0] cnt;
  logic s1_v_q, s1_co_q, wr_v_q, done_q, run, same, accept, coalesce, s1_write;
  always_comb begin
    run = state_q == RUN;
    same = s1_v_q && upd_addr == s1_addr_q;
    upd_ready = run && !(upd_valid && s1_v_q && !same);
    accept = upd_valid && upd_ready;
    coalesce = accept && same && !s1_co_q;
    s1_write = s1_v_q && !coalesce;
    base = s1_co_q ? s1_acc_q : (wr_v_q && wr_addr_q == s1_addr_q) ? wr_data_q : bram_rdata;
    cnt = base[W-1 -: COUNT_W];
    merged = {(&cnt ? cnt : cnt + COUNT_W'(1)), sat(base[3*SUM_W-1 -: SUM_W], s1_x_q),
              sat(base[2*SUM_W-1 -: SUM_W], s1_y_q), sat(base[SUM_W-1:0], s1_z_q)};
    bram_re = accept && !s1_v_q;
    bram_we = state_q == CLEAR ? rst_n : s1_write;
    bram_addr = state_q == CLEAR ? clr_q : s1_write ? s1_addr_q : upd_addr;
    bram_wdata = s1_write ? merged : '0;
    busy = !run;
    clear_done = done_q;
    clr_d = state_q == CLEAR ? clr_q + ADDR_W'(1) : '0;
    state_d = state_q == CLEAR ? (&clr_q ? RUN : CLEAR) :
              run ? (frame_clear ? DRAIN : RUN) : (s1_v_q ? DRAIN : CLEAR);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CLEAR;
      clr_q <= '0;
      done_q <= 1'b0;
      s1_v_q <= 1'b0;
      s1_co_q <= 1'b0;
      wr_v_q <= 1'b0;
      s1_addr_q <= '0;
      wr_addr_q <= '0;
      s1_x_q <= '0;
      s1_y_q <= '0;
      s1_z_q <= '0;
      s1_acc_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      done_q <= state_q == CLEAR && &clr_q;
      s1_v_q <= accept;
      s1_co_q <= coalesce;
      wr_v_q <= s1_write;
      wr_addr_q <= s1_addr_q;
      wr_data_q <= merged;
      if (accept) begin
        s1_addr_q <= upd_addr;
        s1_x_q <= upd_x;
        s1_y_q <= upd_y;
        s1_z_q <= upd_z;
      end
      if (coalesce) s1_acc_q <= merged;
    end
endmodule

// File: tb/tb_voxel_rmw_scheduler.sv
// tb_voxel_rmw_scheduler: directed bench with a memory-level reference model for voxel_rmw_scheduler
module tb_voxel_rmw_scheduler;
  localparam int D = 32768;
  logic clk = 1'b0, rst_n = 1'b0;
  logic upd_valid = 1'b0, frame_clear = 1'b0;
  logic [14:0] upd_addr = '0;
  logic [9:0] upd_x = '0, upd_y = '0, upd_z = '0;
  logic upd_ready, busy, clear_done, bram_re, bram_we;
  logic [14:0] bram_addr;
  logic [79:0] bram_rdata = '0, bram_wdata;
  logic [79:0] mem [D];
  logic [79:0] exp_m [D];
  logic pre_v = 1'b0;
  logic [14:0] pre_a = '0;
  logic [79:0] pre_d = '0;
  int n_cmp = 0, n_bad = 0;
  int touched[$];
  bit inited = 0, in_swp = 1, drn = 0, dn_next = 0;
  int swp_a = 0, drn_n = 0;
  always #5 clk = ~clk;
  voxel_rmw_scheduler dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
    .upd_x(upd_x), .upd_y(upd_y), .upd_z(upd_z), .frame_clear(frame_clear), .busy(busy),
    .clear_done(clear_done), .bram_addr(bram_addr), .bram_re(bram_re), .bram_rdata(bram_rdata),
    .bram_we(bram_we), .bram_wdata(bram_wdata)
  );
  always @(posedge clk) begin
    if (bram_re) bram_rdata <= mem[bram_addr];
    if (pre_v) mem[pre_a] <= pre_d;
    else if (bram_we) mem[bram_addr] <= bram_wdata;
  end
  task automatic chk(input string nm, input logic [99:0] got, input logic [99:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask
  function automatic logic [79:0] acc_word(input logic [79:0] w, input int x, input int y, input int z);
    int c, sx, sy, sz;
    c = int'(w[79:72]) + 1;
    sx = int'(w[71:48]) + x;
    sy = int'(w[47:24]) + y;
    sz = int'(w[23:0]) + z;
    if (c > 255) c = 255;
    if (sx > 16777215) sx = 16777215;
    if (sy > 16777215) sy = 16777215;
    if (sz > 16777215) sz = 16777215;
    return {c[7:0], sx[23:0], sy[23:0], sz[23:0]};
  endfunction
  task automatic flush();
    foreach (touched[i]) chk("mem_contents", mem[touched[i]], exp_m[touched[i]]);
    foreach (touched[i]) exp_m[touched[i]] = '0;
    touched.delete();
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      if (!inited) begin
        foreach (exp_m[i]) exp_m[i] = '0;
        inited = 1;
      end
      chk("reset_values", {upd_ready, busy, clear_done, bram_re, bram_we, bram_addr, bram_wdata},
          {5'b01000, 15'd0, 80'd0});
      foreach (touched[i]) exp_m[touched[i]] = '0;
      touched.delete();
      in_swp = 1; swp_a = 0; drn = 0; dn_next = 0;
    end else begin
      if (drn && bram_we && bram_wdata == 80'd0) begin
        flush();
        in_swp = 1; swp_a = 0; drn = 0;
      end
      if (in_swp) begin
        chk("sweep", {bram_we, bram_addr, bram_wdata, upd_ready, busy, clear_done, bram_re},
            {1'b1, 15'(swp_a), 80'd0, 4'b0100});
        swp_a++;
        if (swp_a == D) begin in_swp = 0; dn_next = 1; end
      end else begin
        chk("busy_done", {busy, clear_done}, {drn, dn_next});
        if (dn_next) chk("ready_after_clear", upd_ready, 1);
        if (drn) begin
          drn_n++;
          chk("drain_ready", upd_ready, 0);
          chk("drain_len_ok", drn_n <= 2, 1);
        end
        if (bram_we) chk("writeback", bram_wdata, exp_m[bram_addr]);
        if (bram_re) chk("read_issue", {upd_valid && upd_ready, bram_we, bram_addr}, {1'b1, 1'b0, upd_addr});
        if (pre_v) begin exp_m[pre_a] = pre_d; touched.push_back(int'(pre_a)); end
        if (upd_valid && upd_ready) begin
          exp_m[upd_addr] = acc_word(exp_m[upd_addr], int'(upd_x), int'(upd_y), int'(upd_z));
          touched.push_back(int'(upd_addr));
        end
        if (frame_clear && !drn) begin drn = 1; drn_n = 0; end
        dn_next = 0;
      end
    end
  end
  task automatic send(input logic [14:0] a, input int x, input int y, input int z, input bit fc, output int n);
    logic r;
    upd_valid = 1'b1; upd_addr = a; upd_x = 10'(x); upd_y = 10'(y); upd_z = 10'(z); frame_clear = fc;
    n = 0;
    do begin
      @(negedge clk); r = upd_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 50);
    chk("send_accept", r, 1);
    upd_valid = 1'b0; frame_clear = 1'b0;
  endtask
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int hi);
    int n = 0;
    hi = 0;
    do begin @(negedge clk); n++; if (upd_ready && !clear_done) hi++; end while (!clear_done && n < 40000);
    chk("clear_done_seen", clear_done, 1);
  endtask
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  logic [14:0] ta [8] = '{15'h300, 15'h300, 15'h300, 15'h301, 15'h300, 15'h302, 15'h302, 15'h300};
  initial begin
    int n, hi;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bram_we && bram_addr == 15'd1000) && n < 2000);
    chk("reach_addr_1000", bram_addr, 15'd1000);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {bram_we, busy, upd_ready, bram_re, bram_addr}, {4'b0100, 15'd0});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_done(hi);
    chk("ready_during_sweep", hi, 0);
    idle(1);
    upd_valid = 1'b1; upd_addr = 15'h1234; upd_x = 10'd5; upd_y = 10'd6; upd_z = 10'd7;
    @(negedge clk);
    chk("s0_read", {upd_ready, bram_re, bram_we, bram_addr}, {3'b110, 15'h1234});
    @(posedge clk);
    #1 upd_valid = 1'b0;
    @(negedge clk);
    chk("s1_write", {bram_we, bram_addr, bram_wdata}, {1'b1, 15'h1234, 8'h01, 24'd5, 24'd6, 24'd7});
    idle(2);
    for (int i = 0; i < 4; i++) begin
      send(15'h0042, 1023, 1023, 1023, 1'b0, n);
      chk("same_addr_no_stall", n, 1);
    end
    idle(4);
    chk("coalesce_final", mem[15'h0042], {8'h04, 24'd4092, 24'd4092, 24'd4092});
    send(15'h0100, 1, 2, 3, 1'b0, n);
    send(15'h0101, 4, 5, 6, 1'b0, n);
    chk("diff_addr_stall", n, 2);
    send(15'h0100, 7, 8, 9, 1'b0, n);
    chk("diff_addr_stall2", n, 2);
    send(15'h0100, 1, 1, 1, 1'b0, n);
    chk("same_after_diff", n, 1);
    idle(3);
    chk("alt_final", mem[15'h0100], {8'h03, 24'd9, 24'd11, 24'd13});
    pre_v = 1'b1; pre_a = 15'h0777; pre_d = {8'hFF, 24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0};
    idle(1);
    pre_v = 1'b0;
    idle(1);
    send(15'h0777, 100, 0, 0, 1'b0, n);
    @(negedge clk);
    chk("saturate", {bram_we, bram_wdata}, {1'b1, 8'hFF, 24'hFFFFFF, 24'hFFFFF0, 24'hFFFFF0});
    idle(2);
    for (int i = 0; i < 8; i++) send(ta[i], i * 100 + 1, i + 7, 1023 - i, 1'b0, n);
    idle(4);
    flush();
    send(15'h0500, 9, 8, 7, 1'b1, n);
    upd_valid = 1'b1; upd_addr = 15'h0600; upd_x = 10'd1; upd_y = 10'd1; upd_z = 10'd1;
    repeat (100) @(negedge clk);
    #1 frame_clear = 1'b1;
    @(posedge clk);
    #1 frame_clear = 1'b0;
    wait_done(hi);
    chk("ready_low_until_done", hi, 0);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    idle(4);
    chk("update_after_clear", mem[15'h0600], {8'h01, 24'd1, 24'd1, 24'd1});
    chk("pre_clear_update_wiped", mem[15'h0500], 80'd0);
    flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
